dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter_rr_pick2.sv | 13 +
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds state encoding, requester indices and default bus widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_wen, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_wen, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone eligible requester wins,
// on a tie the requester other than last_winner wins.
module rr_pick2 (
  input  logic [1:0] eligible,
  input  logic       last_winner,
  output logic       valid,
  output logic       winner
);

  assign valid  = |eligible;
  assign winner = (&eligible) ? ~last_winner : eligible[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter for core (0) and loader (1): one-cycle ACCESS
// per grant, read data returned with rvalid the cycle after the grant; no backpressure.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clock,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);

  state_e            state_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic       in_access;
  logic [1:0] elig;
  logic       pick_vld;
  logic       pick_win;

  assign in_access = (state_q == ACCESS);

  // The requester served this cycle sits out the next arbitration.
  assign elig = {bus.req1 & ~(in_access & gnt1_q),
                 bus.req0 & ~(in_access & gnt0_q)};

  rr_pick2 u_pick (
    .eligible    (elig),
    .last_winner (last_q),
    .valid       (pick_vld),
    .winner      (pick_win)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= REQ_LOADER;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= in_access & gnt0_q & ~we_q;
      rvalid1_q <= in_access & gnt1_q & ~we_q;
      if (in_access && !we_q && gnt0_q) rdata0_q <= bus.mem_rdata;
      if (in_access && !we_q && gnt1_q) rdata1_q <= bus.mem_rdata;

      if (pick_vld) begin
        state_q <= ACCESS;
        gnt0_q  <= (pick_win == REQ_CORE);
        gnt1_q  <= (pick_win == REQ_LOADER);
        we_q    <= pick_win ? bus.we1    : bus.we0;
        addr_q  <= pick_win ? bus.addr1  : bus.addr0;
        wdata_q <= pick_win ? bus.wdata1 : bus.wdata0;
        last_q  <= pick_win;
      end else begin
        state_q <= IDLE;
        gnt0_q  <= 1'b0;
        gnt1_q  <= 1'b0;
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = in_access;
  assign bus.mem_wen   = in_access & we_q;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word behavioural memory.
module tb_dmem_arbiter;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_dat;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) dif ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dif.mem_rdata = mem[dif.mem_addr[7:0]];
  always @(posedge clock) begin
    if (dif.mem_wen) mem[dif.mem_addr[7:0]] <= dif.mem_wdata;
    else if (pre_en) mem[pre_addr] <= pre_dat;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    dif.req0 = 0; dif.req1 = 0; dif.we0 = 0; dif.we1 = 0;
    dif.addr0 = '0; dif.addr1 = '0; dif.wdata0 = '0; dif.wdata1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1; pre_addr = a; pre_dat = d;
    tick();
    pre_en = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    #3;
    n_checks++; if (dif.gnt0 !== 1'b0 || dif.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", dif.gnt1, dif.gnt0); end
    n_checks++; if (dif.rvalid0 !== 1'b0 || dif.rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", dif.rvalid1, dif.rvalid0); end
    n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
    n_checks++; if (dif.mem_wen !== 1'b0 || dif.mem_addr !== 16'h0 || dif.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem: got wen=%b addr=%h wdata=%h want 0/0/0", dif.mem_wen, dif.mem_addr, dif.mem_wdata); end
    n_checks++; if (dif.rdata0 !== 32'h0 || dif.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", dif.rdata0, dif.rdata1); end
    tick();
    reset_n = 1;
  endtask

  task automatic test_lone_read();
    do_reset();
    preload(8'h10, 32'hDEADBEEF);
    dif.req0 = 1; dif.we0 = 0; dif.addr0 = 16'h0010;
    tick();
    n_checks++; if (dif.gnt0 !== 1'b1 || dif.gnt1 !== 1'b0) begin n_fail++; $display("FAIL lone_c1_gnt: got gnt1gnt0=%b%b want 01", dif.gnt1, dif.gnt0); end
    n_checks++; if (dif.mem_addr !== 16'h0010 || dif.mem_wen !== 1'b0 || dif.busy !== 1'b1) begin n_fail++; $display("FAIL lone_c1_mem: got addr=%h wen=%b busy=%b want 0010/0/1", dif.mem_addr, dif.mem_wen, dif.busy); end
    dif.req0 = 0;
    tick();
    n_checks++; if (dif.rvalid0 !== 1'b1 || dif.rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lone_c2_rvalid: got rvalid0=%b rdata0=%h want 1 deadbeef", dif.rvalid0, dif.rdata0); end
    n_checks++; if (dif.gnt0 !== 1'b0 || dif.gnt1 !== 1'b0 || dif.rvalid1 !== 1'b0) begin n_fail++; $display("FAIL lone_c2_idle: got gnt=%b%b rvalid1=%b want 00 0", dif.gnt1, dif.gnt0, dif.rvalid1); end
    tick();
    n_checks++; if (dif.rvalid0 !== 1'b0 || dif.rdata0 !== 32'hDEADBEEF || dif.gnt1 !== 1'b0) begin n_fail++; $display("FAIL lone_c3_hold: got rvalid0=%b rdata0=%h gnt1=%b want 0 deadbeef 0", dif.rvalid0, dif.rdata0, dif.gnt1); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g0;
    preload(8'h01, 32'h11111111);
    preload(8'h02, 32'h22222222);
    do_reset();
    exp_g0 = 4'b0101;
    dif.req0 = 1; dif.addr0 = 16'h0001;
    dif.req1 = 1; dif.addr1 = 16'h0002;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (dif.gnt0 !== exp_g0[c] || dif.gnt1 !== ~exp_g0[c]) begin n_fail++; $display("FAIL cont_gnt_c%0d: got gnt1gnt0=%b%b want %b%b", c+1, dif.gnt1, dif.gnt0, ~exp_g0[c], exp_g0[c]); end
      if (c == 1) begin
        n_checks++; if (dif.rvalid0 !== 1'b1 || dif.rdata0 !== 32'h11111111) begin n_fail++; $display("FAIL cont_rvalid0: got %b %h want 1 11111111", dif.rvalid0, dif.rdata0); end
      end
      if (c == 2) begin
        n_checks++; if (dif.rvalid1 !== 1'b1 || dif.rdata1 !== 32'h22222222) begin n_fail++; $display("FAIL cont_rvalid1: got %b %h want 1 22222222", dif.rvalid1, dif.rdata1); end
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dif.req1 = 1; dif.we1 = 1; dif.addr1 = 16'h0003; dif.wdata1 = 32'h12345678;
    tick();
    n_checks++; if (dif.gnt1 !== 1'b1 || dif.mem_wen !== 1'b1 || dif.mem_addr !== 16'h0003 || dif.mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_write: got gnt1=%b wen=%b addr=%h wdata=%h want 1 1 0003 12345678", dif.gnt1, dif.mem_wen, dif.mem_addr, dif.mem_wdata); end
    dif.we1 = 0; dif.wdata1 = 32'h0;
    tick();
    n_checks++; if (dif.gnt1 !== 1'b0 || dif.mem_wen !== 1'b0 || dif.rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got gnt1=%b wen=%b rvalid1=%b want 0 0 0", dif.gnt1, dif.mem_wen, dif.rvalid1); end
    n_checks++; if (mem[3] !== 32'h12345678) begin n_fail++; $display("FAIL b2b_memword: got %h want 12345678", mem[3]); end
    tick();
    n_checks++; if (dif.gnt1 !== 1'b1 || dif.mem_wen !== 1'b0 || dif.mem_addr !== 16'h0003) begin n_fail++; $display("FAIL b2b_read: got gnt1=%b wen=%b addr=%h want 1 0 0003", dif.gnt1, dif.mem_wen, dif.mem_addr); end
    dif.req1 = 0;
    tick();
    n_checks++; if (dif.rvalid1 !== 1'b1 || dif.rdata1 !== 32'h12345678 || dif.mem_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_rdata: got rvalid1=%b rdata1=%h wen=%b want 1 12345678 0", dif.rvalid1, dif.rdata1, dif.mem_wen); end
  endtask

  task automatic test_lone_rate();
    logic [5:0] exp_g0;
    do_reset();
    exp_g0 = 6'b010101;
    dif.req0 = 1; dif.we0 = 0; dif.addr0 = 16'h0010;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (dif.gnt0 !== exp_g0[c] || dif.gnt1 !== 1'b0) begin n_fail++; $display("FAIL rate_c%0d: got gnt0=%b gnt1=%b want %b 0", c+1, dif.gnt0, dif.gnt1, exp_g0[c]); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    preload(8'h05, 32'hA5A5A5A5);
    dif.req0 = 1; dif.we0 = 1; dif.addr0 = 16'h0005; dif.wdata0 = 32'hBAD0BAD0;
    tick();
    n_checks++; if (dif.mem_wen !== 1'b1 || dif.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_access: got wen=%b gnt0=%b want 1 1", dif.mem_wen, dif.gnt0); end
    #2 reset_n = 0;
    #1;
    n_checks++; if (dif.mem_wen !== 1'b0 || dif.gnt0 !== 1'b0 || dif.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got wen=%b gnt0=%b busy=%b want 0 0 0", dif.mem_wen, dif.gnt0, dif.busy); end
    clear_inputs();
    tick();
    n_checks++; if (mem[5] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rstmid_mem5: got %h want a5a5a5a5", mem[5]); end
    n_checks++; if (dif.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid_a: got %b want 0", dif.rvalid0); end
    reset_n = 1;
    tick();
    n_checks++; if (dif.rvalid0 !== 1'b0 || dif.gnt0 !== 1'b0 || mem[5] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rstmid_after: got rvalid0=%b gnt0=%b mem5=%h want 0 0 a5a5a5a5", dif.rvalid0, dif.gnt0, mem[5]); end
  endtask

  task automatic test_idle_unstable();
    do_reset();
    dif.req1 = 0; dif.we1 = 1; dif.wdata1 = 32'hCAFEF00D;
    for (int c = 0; c < 8; c++) begin
      dif.addr1 = (c % 2 == 0) ? 16'h00AA : 16'h0055;
      tick();
      n_checks++; if (dif.mem_wen !== 1'b0 || dif.gnt1 !== 1'b0) begin n_fail++; $display("FAIL idle_c%0d: got wen=%b gnt1=%b want 0 0", c, dif.mem_wen, dif.gnt1); end
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pre_en   = 0;
    pre_addr = '0;
    pre_dat  = '0;
    reset_n  = 0;
    clear_inputs();
    test_reset();
    test_lone_read();
    test_contention();
    test_back_to_back();
    test_lone_rate();
    test_reset_mid();
    test_idle_unstable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
